data_mem_slave: RTL
===================

# data_mem_slave

Word-organised data RAM that acts as the responder for the pipeline's memory-stage load/store port. It accepts one request at a time over a request/acknowledge handshake and inserts a configurable number of wait states. It performs byte, halfword and word accesses with little-endian lane selection and optional load sign-extension, and flags misaligned addresses. `busy_o` drives the pipeline stall for the whole access, including its wait states.

## Interface
- `ADDR_W`, 10: number of word-index bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: number of wait states inserted before each access completes (0–15).
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `req_i` in 1: access request. The requester holds it and all request fields stable until the cycle of `ack_o`.
- `we_i` in 1: 1 = store, 0 = load.
- `size_i` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `sext_i` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr_i` in 32: byte address, taken from the memory-stage ALU result.
- `wdata_i` in 32: store data. For byte/halfword stores the data is right-aligned in bits 7:0 or 15:0.
- `rdata_o` out 32: load result. Valid in the `ack_o` cycle and held until the next load's ack.
- `ack_o` out 1: one-cycle completion pulse.
- `busy_o` out 1: stall request to the pipeline.
- `adel_o` out 1: misaligned load. Pulses together with `ack_o`.
- `ades_o` out 1: misaligned store. Pulses together with `ack_o`.
- `badaddr_o` out 32: offending address. Updated only on an error ack.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, `req_i`=1:
  - Misaligned request: `size_i`=01 with `addr_i[0]`≠0, or word with `addr_i[1:0]`≠0. Go to RESP with the error flag latched. No array access occurs.
  - Aligned and `WAIT_CYCLES`=0: perform the access on this edge and go to RESP.
  - Aligned otherwise: load the counter with `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 1, perform the access and go to RESP.
- RESP:
  - `ack_o`=1, plus `adel_o`/`ades_o` if the error flag is latched.
  - `req_i` is ignored in this state.
  - Next state is always IDLE.
- Word index is `addr_i[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias.
- Byte lanes are little-endian: lane n = bits 8n+7:8n, selected by `addr_i[1:0]`. Halfword lane is selected by `addr_i[1]`.
- Store: read-modify-write merge of only the addressed lane(s). Untouched lanes keep their value.
- Load:
  - Extract the addressed lane, then zero- or sign-extend according to `sext_i`.
  - Word loads ignore `sext_i`.
  - `rdata_o` is registered at the access edge.
  - On a store ack or error ack, `rdata_o` is unchanged.
- `busy_o` = `req_i`·(state=IDLE) + (state=WAIT). This is combinational from `req_i`, so the pipeline stalls in the same cycle the request appears. It is 0 in RESP, which lets the pipeline advance with the data.
- Array contents are not reset.

## Timing
- Request sampled at edge k in IDLE → `ack_o` high during cycle k+WAIT_CYCLES+1.
- Error ack: always in cycle k+1, independent of `WAIT_CYCLES`.
- Minimum spacing between request samples: WAIT_CYCLES+2 cycles, because RESP → IDLE costs one cycle.
- Reset values: state=IDLE, counter=0, `rdata_o`=0, `ack_o`=0, `busy_o`=0 (with `req_i`=0), `adel_o`=0, `ades_o`=0, `badaddr_o`=0.
- Reset mid-access: `rst` has priority on every edge.
  - If `rst` is high on the edge where a store would commit, the array is not written.
  - The block returns to IDLE and no ack is issued for the aborted request.
- `req_i` dropped by the requester before ack violates the protocol. The block completes the access regardless.

## Structure
- Package `mem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the state enum (IDLE/WAIT/RESP).
- Sub-module `mem_lane` (combinational):
  - Store path: `old_word`, `wdata`, `size`, `addr[1:0]` → merged word.
  - Load path: `word`, `size`, `addr[1:0]`, `sext` → extracted value.
  - The top level holds the FSM, the counter and the array.

## Test plan
- Word store then load, `WAIT_CYCLES`=2:
  - Store 0xDEADBEEF to 0x100.
  - Load 0x100 → `rdata_o`=0xDEADBEEF; ack arrives 3 cycles after the request sample; `busy_o` is high for 3 cycles per access.
- Byte lanes: word 0x00000000 at 0x40, then store byte 0x80 to 0x42.
  - Load word → 0x00800000.
  - Load byte at 0x42 with `sext_i`=1 → 0xFFFFFF80; with `sext_i`=0 → 0x00000080.
- Halfword: store 0x1234 to 0x46, then load word 0x44 → 0x12340000.
  - Load half 0x46 with `sext_i`=1 → 0x00001234.
- Misaligned accesses:
  - Load word at 0x101 → `adel_o`=1 with ack in cycle k+1, `badaddr_o`=0x101, `rdata_o` unchanged.
  - Store half at 0x103 → `ades_o`=1 and memory unchanged.
- Reset mid-access: store 0xAAAAAAAA to 0x200 with `rst` pulsed in WAIT → no ack; a subsequent load of 0x200 returns the prior value.
- `WAIT_CYCLES`=0 build: back-to-back requests → ack every other cycle; `busy_o` is high only in each request cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data RAM responder: access sizes, FSM states, alignment rule.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   // Halfwords need bit 0 clear; words, and the reserved size that behaves as a word, need both bits clear.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lowAddr);
      return ((size == SZ_HALF) && lowAddr[0]) || (size[1] && (lowAddr != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane.sv
// Little-endian lane steering: merges store data into a word and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are used.
module mem_lane
   import mem_pkg::*;
(
   input  logic [31:0] oldWord,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   input  logic        sext,
   output logic [31:0] mergedWord,
   output logic [31:0] loadValue
);

   logic [7:0]  byteVal;
   logic [15:0] halfVal;

   // Store merge: only the addressed lane(s) take new data, the rest keep the old word.
   always_comb begin
      mergedWord = oldWord;
      case (size)
         SZ_BYTE: begin
            case (addr)
               2'd0:    mergedWord[7:0]   = wdata[7:0];
               2'd1:    mergedWord[15:8]  = wdata[7:0];
               2'd2:    mergedWord[23:16] = wdata[7:0];
               default: mergedWord[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (addr[1]) mergedWord[31:16] = wdata[15:0];
            else         mergedWord[15:0]  = wdata[15:0];
         end
         default: mergedWord = wdata;
      endcase
   end

   // Load extract: pick the lane, then zero- or sign-extend; full words pass untouched.
   always_comb begin
      case (addr)
         2'd0:    byteVal = word[7:0];
         2'd1:    byteVal = word[15:8];
         2'd2:    byteVal = word[23:16];
         default: byteVal = word[31:24];
      endcase
      halfVal = addr[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: loadValue = {{24{sext & byteVal[7]}}, byteVal};
         SZ_HALF: loadValue = {{16{sext & halfVal[15]}}, halfVal};
         default: loadValue = word;
      endcase
   end

endmodule

// File: rtl/data_mem_slave.sv
// Word-organised data RAM answering the memory-stage load/store port, with misalignment flags.
// Latency: ack WAIT_CYCLES+1 cycles after the request is sampled; misaligned requests ack after 1.
// Backpressure: busy_o stalls the pipeline from the request cycle through the wait states, drops in the ack cycle.
module data_mem_slave
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        busy_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic [31:0] badaddr_o
);

   localparam int         DEPTH     = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t            state;
   state_t            stateNext;
   logic [3:0]        waitCnt;
   logic [3:0]        waitCntNext;
   logic              errLoad;
   logic              errStore;
   logic              misaligned;
   logic              doAccess;

   // Request fields captured at the sample edge so a requester that misbehaves cannot corrupt the access.
   logic              reqWe;
   logic [1:0]        reqSize;
   logic              reqSext;
   logic [ADDR_W+1:0] reqAddr;
   logic [31:0]       reqWdata;

   logic              accWe;
   logic [1:0]        accSize;
   logic              accSext;
   logic [ADDR_W+1:0] accAddr;
   logic [31:0]       accWdata;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wordIdx;
   logic [31:0]       curWord;
   logic [31:0]       mergedWord;
   logic [31:0]       loadValue;

   assign misaligned = isMisaligned(size_i, addr_i[1:0]);

   // Zero-wait accesses happen straight from IDLE on live inputs; otherwise use the captured request.
   always_comb begin
      if (state == IDLE) begin
         accWe    = we_i;
         accSize  = size_i;
         accSext  = sext_i;
         accAddr  = addr_i[ADDR_W+1:0];
         accWdata = wdata_i;
      end else begin
         accWe    = reqWe;
         accSize  = reqSize;
         accSext  = reqSext;
         accAddr  = reqAddr;
         accWdata = reqWdata;
      end
   end

   assign wordIdx = accAddr[ADDR_W+1:2];
   assign curWord = mem[wordIdx];

   mem_lane uLane (
      .oldWord    (curWord),
      .wdata      (accWdata),
      .size       (accSize),
      .addr       (accAddr[1:0]),
      .word       (curWord),
      .sext       (accSext),
      .mergedWord (mergedWord),
      .loadValue  (loadValue)
   );

   // Next-state, wait counter and handshake outputs.
   always_comb begin
      stateNext   = state;
      waitCntNext = waitCnt;
      doAccess    = 1'b0;
      ack_o       = 1'b0;
      busy_o      = 1'b0;
      adel_o      = 1'b0;
      ades_o      = 1'b0;
      case (state)
         IDLE: begin
            busy_o = req_i;
            if (req_i) begin
               if (misaligned) begin
                  stateNext = RESP;
               end else if (WAIT_CYCLES == 0) begin
                  doAccess  = 1'b1;
                  stateNext = RESP;
               end else begin
                  waitCntNext = WAIT_LOAD;
                  stateNext   = WAIT;
               end
            end
         end
         WAIT: begin
            busy_o      = 1'b1;
            waitCntNext = waitCnt - 4'd1;
            if (waitCnt == 4'd1) begin
               doAccess  = 1'b1;
               stateNext = RESP;
            end
         end
         RESP: begin
            ack_o     = 1'b1;
            adel_o    = errLoad;
            ades_o    = errStore;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // State, counter, error flags and the registered load/bad-address outputs; reset wins on every edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         waitCnt   <= 4'd0;
         errLoad   <= 1'b0;
         errStore  <= 1'b0;
         rdata_o   <= 32'd0;
         badaddr_o <= 32'd0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         if (state == IDLE && req_i) begin
            errLoad  <= misaligned & ~we_i;
            errStore <= misaligned & we_i;
            if (misaligned) badaddr_o <= addr_i;
         end
         if (doAccess && !accWe) rdata_o <= loadValue;
      end
   end

   // Capture the request fields when the request is sampled in IDLE.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_i) begin
         reqWe    <= we_i;
         reqSize  <= size_i;
         reqSext  <= sext_i;
         reqAddr  <= addr_i[ADDR_W+1:0];
         reqWdata <= wdata_i;
      end
   end

   // Array write: read-modify-write of the addressed lanes; a reset on the commit edge suppresses it.
   always_ff @(posedge clk) begin
      if (!rst && doAccess && accWe) mem[wordIdx] <= mergedWord;
   end

endmodule
